// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller with IR, IDCODE, BYPASS and DMI DR, oversampled in clk
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH    = 5,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          DMI_WIDTH   = 41,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tck,
  input  logic                 tms,
  input  logic                 tdi,
  input  logic                 trst,
  output logic                 tdo,
  output logic [IR_WIDTH-1:0]  ir,
  output logic [3:0]           tap_state,
  output logic                 dmi_capture_req,
  input  logic [DMI_WIDTH-1:0] dmi_capture_data,
  output logic                 dmi_update,
  output logic [DMI_WIDTH-1:0] dmi_update_data
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

  typedef enum logic [3:0] {
    TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
    SHDR  = 4'd4,  EX1DR = 4'd5,  PADR  = 4'd6,  EX2DR = 4'd7,
    UPDDR = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
    EX1IR = 4'd12, PAIR  = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15
  } tap_state_e;

  tap_state_e state, state_nxt;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s, trst_s;
  logic                   tck_rise, tck_fall;

  logic [IR_WIDTH-1:0]  ir_sh;
  logic [31:0]          idcode_sh;
  logic [DMI_WIDTH-1:0] dmi_sh;
  logic [DMI_WIDTH-1:0] dmi_hold;
  logic                 bypass_sh;
  logic                 dr_lsb;

  // Pin synchronizers plus one extra tck sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      trst_sync <= '0;
      tck_prev  <= 1'b0;
    end else begin
      tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst};
      tck_prev  <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign trst_s   = trst_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;

  // Debug module samples dmi_capture_data on the step from Select-DR into Capture-DR
  assign dmi_capture_req = tck_rise & ~trst_s & (state == SELDR) & ~tms_s & (ir == IR_DMI);

  // Output bit of whichever data register the current instruction selects
  always_comb begin
    dr_lsb = bypass_sh;
    if (ir == IR_IDCODE)   dr_lsb = idcode_sh[0];
    else if (ir == IR_DMI) dr_lsb = dmi_sh[0];
  end

  // TAP state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TLR;
    else     state <= state_nxt;
  end

  // TAP next state: trst forces TLR, otherwise step on each tck rise
  always_comb begin
    state_nxt = state;
    if (trst_s) begin
      state_nxt = TLR;
    end else if (tck_rise) begin
      case (state)
        TLR:     state_nxt = tms_s ? TLR   : RTI;
        RTI:     state_nxt = tms_s ? SELDR : RTI;
        SELDR:   state_nxt = tms_s ? SELIR : CAPDR;
        CAPDR:   state_nxt = tms_s ? EX1DR : SHDR;
        SHDR:    state_nxt = tms_s ? EX1DR : SHDR;
        EX1DR:   state_nxt = tms_s ? UPDDR : PADR;
        PADR:    state_nxt = tms_s ? EX2DR : PADR;
        EX2DR:   state_nxt = tms_s ? UPDDR : SHDR;
        UPDDR:   state_nxt = tms_s ? SELDR : RTI;
        SELIR:   state_nxt = tms_s ? TLR   : CAPIR;
        CAPIR:   state_nxt = tms_s ? EX1IR : SHIR;
        SHIR:    state_nxt = tms_s ? EX1IR : SHIR;
        EX1IR:   state_nxt = tms_s ? UPDIR : PAIR;
        PAIR:    state_nxt = tms_s ? EX2IR : PAIR;
        EX2IR:   state_nxt = tms_s ? UPDIR : SHIR;
        UPDIR:   state_nxt = tms_s ? SELDR : RTI;
        default: state_nxt = TLR;
      endcase
    end
  end

  // Register actions keyed on the state held at tck rise, tdo on tck fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir         <= IR_IDCODE;
      ir_sh      <= '0;
      idcode_sh  <= '0;
      dmi_sh     <= '0;
      dmi_hold   <= '0;
      bypass_sh  <= 1'b0;
      tdo        <= 1'b0;
      dmi_update <= 1'b0;
    end else begin
      dmi_update <= 1'b0;
      if (trst_s) begin
        ir  <= IR_IDCODE;
        tdo <= 1'b0;
      end else begin
        if (dmi_capture_req) dmi_hold <= dmi_capture_data;
        if (tck_rise) begin
          case (state)
            CAPIR: ir_sh <= IR_WIDTH'(2'b01);
            SHIR:  ir_sh <= {tdi_s, ir_sh[IR_WIDTH-1:1]};
            UPDIR: ir    <= ir_sh;
            CAPDR: begin
              if (ir == IR_IDCODE)   idcode_sh <= IDCODE_VAL;
              else if (ir == IR_DMI) dmi_sh    <= dmi_hold;
              else                   bypass_sh <= 1'b0;
            end
            SHDR: begin
              if (ir == IR_IDCODE)   idcode_sh <= {tdi_s, idcode_sh[31:1]};
              else if (ir == IR_DMI) dmi_sh    <= {tdi_s, dmi_sh[DMI_WIDTH-1:1]};
              else                   bypass_sh <= tdi_s;
            end
            UPDDR: if (ir == IR_DMI) dmi_update <= 1'b1;
            default: ;
          endcase
        end
        if (tck_fall) begin
          case (state)
            SHIR:    tdo <= ir_sh[0];
            SHDR:    tdo <= dr_lsb;
            default: tdo <= 1'b0;
          endcase
        end
        if (state == TLR) ir <= IR_IDCODE;
      end
    end
  end

  assign tap_state       = state;
  assign dmi_update_data = dmi_sh;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - randomized self-checking bench for jtag_tap_ctrl against a TAP reference model
module tb_jtag_tap_ctrl;

  localparam int IRW = 5;
  localparam int DW  = 41;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tck = 1'b0;
  logic          tms = 1'b0;
  logic          tdi = 1'b0;
  logic          trst = 1'b0;
  logic          tdo;
  logic [IRW-1:0] ir;
  logic [3:0]    tap_state;
  logic          dmi_capture_req;
  logic [DW-1:0] dmi_capture_data = '0;
  logic          dmi_update;
  logic [DW-1:0] dmi_update_data;

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .IDCODE_VAL(32'h1000_0001), .DMI_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo), .ir(ir),
    .tap_state(tap_state), .dmi_capture_req(dmi_capture_req), .dmi_capture_data(dmi_capture_data),
    .dmi_update(dmi_update), .dmi_update_data(dmi_update_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed strobe counts
  int            upd_cnt = 0;
  int            req_cnt = 0;
  logic [DW-1:0] upd_data = '0;
  always @(posedge clk) begin
    if (dmi_update) begin
      upd_cnt  <= upd_cnt + 1;
      upd_data <= dmi_update_data;
    end
    if (dmi_capture_req) req_cnt <= req_cnt + 1;
  end

  // Reference model: IEEE 1149.1 transition table plus shift registers held as value/length
  int            nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int            nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int            m_state, m_ir, m_len;
  bit            m_tdo;
  logic [63:0]   m_irsh, m_dr;
  logic [DW-1:0] m_hold;
  int            e_upd = 0;
  int            e_req = 0;
  logic [DW-1:0] e_upd_data = '0;
  bit            rnd_cap = 0;

  task automatic model_reset();
    m_state = 0; m_ir = 1; m_tdo = 0; m_irsh = 0; m_dr = 0; m_len = 1; m_hold = '0;
  endtask

  task automatic model_rise(input bit t, input bit d);
    int p;
    p = m_state;
    case (p)
      10: m_irsh = 64'd1;
      11: m_irsh = (m_irsh >> 1) | (64'(d) << (IRW - 1));
      15: m_ir = int'(m_irsh);
      3: begin
        if (m_ir == 1)       begin m_dr = 64'h1000_0001; m_len = 32; end
        else if (m_ir == 17) begin m_dr = 64'(m_hold);   m_len = DW; end
        else                 begin m_dr = 64'd0;         m_len = 1;  end
      end
      4: m_dr = (m_dr >> 1) | (64'(d) << (m_len - 1));
      8: if (m_ir == 17) begin e_upd++; e_upd_data = m_dr[DW-1:0]; end
      default: ;
    endcase
    if (p == 2 && !t && m_ir == 17) begin e_req++; m_hold = dmi_capture_data; end
    m_state = t ? nx1[p] : nx0[p];
    if (m_state == 0) m_ir = 1;
  endtask

  task automatic model_fall();
    if (m_state == 11)     m_tdo = m_irsh[0];
    else if (m_state == 4) m_tdo = m_dr[0];
    else                   m_tdo = 0;
  endtask

  task automatic tck_cycle(input bit t, input bit d, output bit o);
    @(negedge clk);
    tms = t; tdi = d;
    if (rnd_cap) dmi_capture_data = {9'($urandom), $urandom};
    repeat (4) @(negedge clk);
    tck = 1'b1;
    model_rise(t, d);
    repeat (6) @(negedge clk);
    check("state_rise", 64'(tap_state), 64'(m_state));
    check("tdo_stable", 64'(tdo), 64'(m_tdo));
    check("ir", 64'(ir), 64'(m_ir));
    tck = 1'b0;
    model_fall();
    repeat (6) @(negedge clk);
    check("tdo", 64'(tdo), 64'(m_tdo));
    check("upd_cnt", 64'(upd_cnt), 64'(e_upd));
    check("req_cnt", 64'(req_cnt), 64'(e_req));
    if (e_upd > 0) check("upd_data", 64'(upd_data), 64'(e_upd_data));
    o = tdo;
  endtask

  // From RTI/UPD: scan n bits of din through IR or DR, returning tdo bits, ending in RTI
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
    bit o;
    dout = '0;
    tck_cycle(1, 0, o);
    if (is_ir) tck_cycle(1, 0, o);
    tck_cycle(0, 0, o);
    tck_cycle(0, 0, o);
    dout[0] = o;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o);
      if (i < n - 1) dout[i+1] = o;
    end
    tck_cycle(1, 0, o);
    tck_cycle(0, 0, o);
  endtask

  task automatic to_rti();
    bit o;
    repeat (5) tck_cycle(1, 0, o);
    tck_cycle(0, 0, o);
  endtask

  task automatic trst_pulse();
    @(negedge clk);
    trst = 1'b1;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    m_state = 0; m_ir = 1; m_tdo = 0;
    check("trst_state", 64'(tap_state), 64'(m_state));
    check("trst_ir", 64'(ir), 64'(m_ir));
    check("trst_tdo", 64'(tdo), 64'(m_tdo));
    repeat (3) @(negedge clk);
    trst = 1'b0;
    repeat (SS + 2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] din;
    bit          o;
    int          s;
    int          op;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 64'(tap_state), 64'd0);
    check("rst_ir", 64'(ir), 64'h01);
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_upd", 64'(dmi_update), 64'd0);
    check("rst_req", 64'(dmi_capture_req), 64'd0);
    rst = 1'b0;
    model_reset();

    to_rti();
    check("t1_state", 64'(tap_state), 64'd1);
    check("t1_ir", 64'(ir), 64'h01);

    // IDCODE readout
    scan(0, 32, 64'd0, d);
    check("idcode", 64'(d[31:0]), 64'h1000_0001);

    // BYPASS
    scan(1, 5, 64'h1F, d);
    check("ir_capture", 64'(d[4:0]), 64'h01);
    check("ir_bypass", 64'(ir), 64'h1F);
    scan(0, 8, 64'hA5, d);
    check("bypass", 64'(d[7:0]), 64'h4A);

    // DMI capture and update
    dmi_capture_data = 41'h1_2345_6789_A;
    scan(1, 5, 64'h11, d);
    s = upd_cnt;
    scan(0, 41, 64'h0AB_CDEF_0123, d);
    check("dmi_out", 64'(d[40:0]), 64'h1_2345_6789_A);
    check("dmi_upd_pulses", 64'(upd_cnt - s), 64'd1);
    check("dmi_upd_val", 64'(upd_data), 64'h0AB_CDEF_0123);

    // trst mid DR shift
    s = upd_cnt;
    tck_cycle(1, 0, o);
    tck_cycle(0, 0, o);
    tck_cycle(0, 0, o);
    repeat (10) tck_cycle(0, 1'($urandom), o);
    trst_pulse();
    check("trst_no_upd", 64'(upd_cnt - s), 64'd0);

    // rst between edges in Exit1-IR
    s = upd_cnt;
    tck_cycle(0, 0, o);
    tck_cycle(1, 0, o);
    tck_cycle(1, 0, o);
    tck_cycle(0, 0, o);
    tck_cycle(0, 1, o);
    tck_cycle(0, 1, o);
    tck_cycle(1, 1, o);
    check("pre_rst_state", 64'(tap_state), 64'd12);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_state", 64'(tap_state), 64'd0);
    check("arst_ir", 64'(ir), 64'h01);
    check("arst_tdo", 64'(tdo), 64'd0);
    check("arst_upd", 64'(dmi_update), 64'd0);
    check("arst_req", 64'(dmi_capture_req), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    tck_cycle(0, 0, o);
    check("resume_rti", 64'(tap_state), 64'd1);
    check("arst_no_upd", 64'(upd_cnt - s), 64'd0);

    // Randomized mix of scans, walks and trst pulses
    rnd_cap = 1;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          case ($urandom_range(0, 3))
            0: din = 64'h01;
            1: din = 64'h11;
            2: din = 64'h1F;
            default: din = 64'($urandom_range(0, 31));
          endcase
          scan(1, 5, din, d);
        end
        1: begin
          din = {$urandom, $urandom};
          scan(0, $urandom_range(1, 45), din, d);
        end
        2: begin
          repeat (12) tck_cycle($urandom_range(0, 99) < 40, 1'($urandom), o);
          to_rti();
        end
        default: begin
          repeat (4) tck_cycle($urandom_range(0, 99) < 40, 1'($urandom), o);
          trst_pulse();
          tck_cycle(0, 0, o);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
